// File: rtl/serial_subtractor_ctrl.sv
`timescale 1ns/1ps
// Bit-serial N-bit subtractor sequencer: diff = a - b - borrow_in, one bit per
// clock through a single shared full-subtractor cell, LSB first.

module fullsubtractor_struct (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             w_cell_d;
    logic             w_cell_bout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    fullsubtractor_struct u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_brw),
        .d    (w_cell_d),
        .bout (w_cell_bout)
    );

    assign w_res_next = {w_cell_d, r_res_sr[WIDTH-1:1]};
    assign w_last     = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so no output decodes logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_SHIFT);
            r_done <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_brw        <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_brw  <= borrow_in;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_brw    <= w_cell_bout;
                    r_res_sr <= w_res_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_cell_bout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign dbg_state  = r_state;
endmodule
